mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: max consecutive locked dbg grants while cpu_req is pending.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_reset  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req  input  1  CPU access request; held until cpu_ack.
REQ-005 cpu_rw  input  1  CPU direction: 1 = read, 0 = write.
REQ-006 cpu_adr  input  16  CPU address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 cpu_rdata  output  8  registered read data to CPU.
REQ-010 dbg_req  input  1  debug-unit access request; held until dbg_ack.
REQ-011 dbg_rw  input  1  debug direction: 1 = read, 0 = write.
REQ-012 dbg_adr  input  16  debug address.
REQ-013 dbg_wdata  input  8  debug write data.
REQ-014 dbg_lock  input  1  debug requests burst priority over CPU.
REQ-015 dbg_ack  output  1  one-cycle completion pulse to debug unit.
REQ-016 dbg_rdata  output  8  registered read data to debug unit.
REQ-017 mem_adr  output  16  memory address.
REQ-018 mem_wdata  output  8  memory write data.
REQ-019 mem_rdata  input  8  memory read data, combinationally valid while mem_en=1 and mem_we=0.
REQ-020 mem_en  output  1  memory access strobe.
REQ-021 mem_we  output  1  memory write enable; valid only with mem_en.
REQ-022 busy  output  1  high while state is not IDLE.

Function
REQ-023 FSM states: IDLE, ACC_CPU, ACC_DBG.
REQ-024 IDLE: arbitrate among eligible requesters; eligible = req high and own ack not high this cycle (masks the cycle the requester is still dropping req).
REQ-025 Arbitration order: locked dbg (dbg_req & dbg_lock & burst_cnt < MAX_BURST) wins; else single requester wins; else tie goes to requester not granted last (round-robin).
REQ-026 Winner: next state ACC_CPU or ACC_DBG; winner's adr/wdata/rw are selected onto mem_* during the ACC state; none eligible: stay IDLE.
REQ-027 ACC_x: mem_en=1, mem_we=~x_rw, mem_adr=x_adr, mem_wdata=x_wdata; other states: mem_en=0, mem_we=0, mem_adr/mem_wdata=0.
REQ-028 ACC_x always returns to IDLE next cycle; on that edge, on read x_rdata <= mem_rdata, on write x_rdata unchanged; x_ack=1 for exactly the following IDLE cycle.
REQ-029 Latency: req sampled in IDLE cycle N -> mem_en in N+1 -> ack in N+2; max throughput one access per 2 cycles.
REQ-030 last_grant register updates on each grant to the winner's identity.
REQ-031 burst_cnt (width clog2(MAX_BURST)+1): +1 on each dbg grant while cpu_req=1; cleared on cpu grant or any IDLE cycle with cpu_req=0; saturates at MAX_BURST.
REQ-032 At burst_cnt = MAX_BURST with cpu eligible, CPU wins the next arbitration regardless of dbg_lock.
REQ-033 Requester dropping req during its ACC state: access completes, ack still issued.
REQ-034 Address/data changes by the non-granted requester have no effect on mem_*.
REQ-035 No combinational path from any *_req to mem_* or *_ack.

Reset
REQ-036 n_reset low asynchronously forces state IDLE, mem_en=0, mem_we=0, mem_adr=0, mem_wdata=0, cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0, burst_cnt=0, last_grant=CPU (first tie goes to dbg), busy=0.
REQ-037 Reset during ACC_x aborts access: no ack issued after release; first arbitration occurs in first IDLE cycle after n_reset rises.

Verification
REQ-038 Single cpu read adr 0x1234, mem_rdata=0xA5 -> mem_en/mem_we=1/0 one cycle later, cpu_ack pulse +2 cycles, cpu_rdata=0xA5.
REQ-039 Single dbg write adr 0x0200 data 0x3C -> one cycle mem_en=1, mem_we=1, mem_adr=0x0200, mem_wdata=0x3C; dbg_ack pulse; dbg_rdata unchanged.
REQ-040 Both req held continuously, no lock, from reset -> grants alternate DBG, CPU, DBG, CPU; each ack one cycle wide.
REQ-041 dbg_lock=1 with both req held, MAX_BURST=4 -> 4 dbg grants, 1 cpu grant, repeating.
REQ-042 n_reset pulsed low during ACC_CPU -> mem_en drops immediately, no cpu_ack, all outputs at reset values.
REQ-043 cpu_req dropped during ACC_CPU -> cpu_ack still pulses once; no re-grant of CPU in ack cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a CPU and a debug unit share one single-cycle memory port.
// Each access takes one ACC cycle, followed by an IDLE cycle that carries the ack.
// Debug may lock priority for a bounded burst while the CPU waits.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic        dbg_rw,
  input  logic [15:0] dbg_adr,
  input  logic [7:0]  dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StAccCpu, StAccDbg} state_e;

  state_e          state_q, state_d;
  logic            last_dbg_q, last_dbg_d;  // 1: most recent grant went to debug
  logic [CntW-1:0] burst_q, burst_d;
  logic            cpu_ack_q, dbg_ack_q;
  logic [7:0]      cpu_rdata_q, dbg_rdata_q;

  logic cpu_elig, dbg_elig, dbg_locked;
  logic grant_cpu, grant_dbg;

  // A requester still showing req in its own ack cycle is about to drop it; ignore it.
  assign cpu_elig   = cpu_req & ~cpu_ack_q;
  assign dbg_elig   = dbg_req & ~dbg_ack_q;
  assign dbg_locked = dbg_req & dbg_lock & (burst_q < MaxCnt);

  // Arbitration, next state, last-grant and burst-counter update.
  always_comb begin
    state_d    = state_q;
    last_dbg_d = last_dbg_q;
    burst_d    = burst_q;
    grant_cpu  = 1'b0;
    grant_dbg  = 1'b0;
    case (state_q)
      StIdle: begin
        if (dbg_locked) begin
          grant_dbg = 1'b1;
        end else if (cpu_elig && dbg_elig) begin
          grant_cpu = last_dbg_q;
          grant_dbg = ~last_dbg_q;
        end else begin
          grant_cpu = cpu_elig;
          grant_dbg = dbg_elig;
        end

        if (grant_cpu) begin
          state_d    = StAccCpu;
          last_dbg_d = 1'b0;
        end else if (grant_dbg) begin
          state_d    = StAccDbg;
          last_dbg_d = 1'b1;
        end

        // Burst only counts debug grants that actually make the CPU wait.
        if (!cpu_req || grant_cpu) begin
          burst_d = '0;
        end else if (grant_dbg && (burst_q < MaxCnt)) begin
          burst_d = burst_q + CntW'(1);
        end
      end
      StAccCpu, StAccDbg: state_d = StIdle;
      default:            state_d = StIdle;
    endcase
  end

  // State, arbitration history and burst counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= StIdle;
      last_dbg_q <= 1'b0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      burst_q    <= burst_d;
    end
  end

  // Completion pulses and read-data capture on the ACC -> IDLE edge.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_ack_q <= (state_q == StAccCpu);
      dbg_ack_q <= (state_q == StAccDbg);
      if ((state_q == StAccCpu) && cpu_rw) begin
        cpu_rdata_q <= mem_rdata;
      end
      if ((state_q == StAccDbg) && dbg_rw) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory port is driven only from the registered state, never from a req line.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    case (state_q)
      StAccCpu: begin
        mem_en    = 1'b1;
        mem_we    = ~cpu_rw;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
      end
      StAccDbg: begin
        mem_en    = 1'b1;
        mem_we    = ~dbg_rw;
        mem_adr   = dbg_adr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single accesses, round-robin, locked bursts,
// reset abort and requester drop during access.
module tb_mem_arbiter;

  logic        clk;
  logic        n_reset;
  logic        cpu_req, cpu_rw, dbg_req, dbg_rw, dbg_lock;
  logic [15:0] cpu_adr, dbg_adr;
  logic [7:0]  cpu_wdata, dbg_wdata, mem_rdata;
  logic        cpu_ack, dbg_ack, mem_en, mem_we, busy;
  logic [7:0]  cpu_rdata, dbg_rdata, mem_wdata;
  logic [15:0] mem_adr;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_adr   (cpu_adr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_rw    (dbg_rw),
    .dbg_adr   (dbg_adr),
    .dbg_wdata (dbg_wdata),
    .dbg_lock  (dbg_lock),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_reset  = 1'b0;
    cpu_req  = 1'b0;
    dbg_req  = 1'b0;
    dbg_lock = 1'b0;
    step();
    step();
    n_reset = 1'b1;
  endtask

  initial begin
    n_reset   = 1'b0;
    cpu_req   = 1'b0; cpu_rw = 1'b0; cpu_adr = '0; cpu_wdata = '0;
    dbg_req   = 1'b0; dbg_rw = 1'b0; dbg_adr = '0; dbg_wdata = '0;
    dbg_lock  = 1'b0;
    mem_rdata = '0;
    #1;
    chk("rst_mem_en",    16'(mem_en),    16'h0);
    chk("rst_mem_we",    16'(mem_we),    16'h0);
    chk("rst_mem_adr",   mem_adr,        16'h0);
    chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
    chk("rst_cpu_ack",   16'(cpu_ack),   16'h0);
    chk("rst_dbg_ack",   16'(dbg_ack),   16'h0);
    chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
    chk("rst_dbg_rdata", 16'(dbg_rdata), 16'h0);
    chk("rst_busy",      16'(busy),      16'h0);
    step();
    step();
    n_reset = 1'b1;

    // Single CPU read; debug changes its bus while not granted.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_adr = 16'h1234; cpu_wdata = 8'h77; mem_rdata = 8'hA5;
    step();
    chk("cpurd_mem_en",  16'(mem_en),  16'h1);
    chk("cpurd_mem_we",  16'(mem_we),  16'h0);
    chk("cpurd_mem_adr", mem_adr,      16'h1234);
    chk("cpurd_busy",    16'(busy),    16'h1);
    chk("cpurd_ack_early", 16'(cpu_ack), 16'h0);
    dbg_adr = 16'hBEEF; dbg_wdata = 8'h99;
    #1;
    chk("cpurd_adr_isolated",   mem_adr,        16'h1234);
    chk("cpurd_wdata_isolated", 16'(mem_wdata), 16'h0077);
    step();
    chk("cpurd_ack",    16'(cpu_ack),   16'h1);
    chk("cpurd_rdata",  16'(cpu_rdata), 16'h00A5);
    chk("cpurd_idle",   16'(mem_en),    16'h0);
    chk("cpurd_busy0",  16'(busy),      16'h0);
    step();  // req still high in ack cycle: must be masked
    chk("cpurd_masked", 16'(mem_en),  16'h0);
    chk("cpurd_ack1w",  16'(cpu_ack), 16'h0);
    cpu_req = 1'b0;
    step();
    chk("cpurd_quiet",  16'(mem_en),  16'h0);

    // Debug read (req dropped during ACC), then debug write.
    dbg_req = 1'b1; dbg_rw = 1'b1; dbg_adr = 16'h0010; mem_rdata = 8'h5A;
    step();
    chk("dbgrd_mem_en",  16'(mem_en), 16'h1);
    chk("dbgrd_mem_adr", mem_adr,     16'h0010);
    dbg_req = 1'b0;
    step();
    chk("dbgrd_ack",     16'(dbg_ack),   16'h1);
    chk("dbgrd_rdata",   16'(dbg_rdata), 16'h005A);
    chk("dbgrd_cpu_rd",  16'(cpu_rdata), 16'h00A5);
    step();
    chk("dbgrd_ack0",    16'(dbg_ack),   16'h0);

    dbg_req = 1'b1; dbg_rw = 1'b0; dbg_adr = 16'h0200; dbg_wdata = 8'h3C; mem_rdata = 8'hFF;
    step();
    chk("dbgwr_mem_en",    16'(mem_en),    16'h1);
    chk("dbgwr_mem_we",    16'(mem_we),    16'h1);
    chk("dbgwr_mem_adr",   mem_adr,        16'h0200);
    chk("dbgwr_mem_wdata", 16'(mem_wdata), 16'h003C);
    step();
    chk("dbgwr_ack",       16'(dbg_ack),   16'h1);
    chk("dbgwr_rdata",     16'(dbg_rdata), 16'h005A);
    dbg_req = 1'b0;
    step();
    chk("dbgwr_ack0",      16'(dbg_ack),   16'h0);
    chk("dbgwr_idle",      16'(mem_en),    16'h0);

    // Round-robin: both held, no lock, from reset -> D C D C D C.
    do_reset();
    cpu_adr = 16'h1111; dbg_adr = 16'h2222; cpu_rw = 1'b1; dbg_rw = 1'b1;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      step();
      chk("rr_en",  16'(mem_en), 16'h1);
      chk("rr_adr", mem_adr, (g % 2 == 0) ? 16'h2222 : 16'h1111);
      chk("rr_acks_acc", {14'h0, cpu_ack, dbg_ack}, 16'h0);
      step();
      chk("rr_gap", 16'(mem_en), 16'h0);
      chk("rr_acks", {14'h0, cpu_ack, dbg_ack}, (g % 2 == 0) ? 16'h1 : 16'h2);
    end

    // Locked burst: D D D D C repeating.
    do_reset();
    dbg_lock = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
    for (int g = 0; g < 10; g++) begin
      step();
      chk("lock_en",  16'(mem_en), 16'h1);
      chk("lock_adr", mem_adr, (g % 5 == 4) ? 16'h1111 : 16'h2222);
      step();
      chk("lock_acks", {14'h0, cpu_ack, dbg_ack}, (g % 5 == 4) ? 16'h2 : 16'h1);
    end

    // Reset pulse during ACC_CPU aborts the access.
    do_reset();
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_adr = 16'h1234; mem_rdata = 8'hC3;
    step();
    chk("abort_acc", 16'(mem_en), 16'h1);
    #1 n_reset = 1'b0;
    #1;
    chk("abort_en",    16'(mem_en),    16'h0);
    chk("abort_adr",   mem_adr,        16'h0);
    chk("abort_busy",  16'(busy),      16'h0);
    chk("abort_rdata", 16'(cpu_rdata), 16'h0);
    cpu_req = 1'b0;
    step();
    n_reset = 1'b1;
    step();
    chk("abort_noack",  16'(cpu_ack),   16'h0);
    chk("abort_rdata2", 16'(cpu_rdata), 16'h0);
    step();
    chk("abort_noack2", 16'(cpu_ack), 16'h0);
    chk("abort_idle",   16'(mem_en),  16'h0);

    // CPU drops req during its ACC: ack still issued, no re-grant.
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_adr = 16'h4321; mem_rdata = 8'h81;
    step();
    chk("drop_acc", 16'(mem_en), 16'h1);
    cpu_req = 1'b0;
    step();
    chk("drop_ack",   16'(cpu_ack),   16'h1);
    chk("drop_rdata", 16'(cpu_rdata), 16'h0081);
    chk("drop_noacc", 16'(mem_en),    16'h0);
    step();
    chk("drop_ack0",  16'(cpu_ack), 16'h0);
    chk("drop_idle",  16'(mem_en),  16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
